// File: rtl/shake_squeeze_pkg.sv
// shake_squeeze_pkg: shared SHAKE constants, state encoding and rate lookup.
package shake_squeeze_pkg;
  localparam int ADDR_W = 7;
  localparam logic [ADDR_W-1:0] RATE_128 = 7'd42;
  localparam logic [ADDR_W-1:0] RATE_256 = 7'd34;
  typedef enum logic [2:0] {IDLE, WAIT_CORE, READ, PERMUTE, DONE} state_t;
  function automatic logic [ADDR_W-1:0] rate_of(input logic m);
    return m ? RATE_256 : RATE_128;
  endfunction
endpackage

// File: rtl/shake_out_fifo.sv
// shake_out_fifo: two-entry output buffer with simultaneous push and pop.
module shake_out_fifo (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [31:0] din,
  input  logic        pop,
  output logic [31:0] dout,
  output logic        valid,
  output logic [1:0]  count
);
  logic [31:0] mem [2];
  logic wp, rp;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + 2'(push) - 2'(pop);
    end
  end
  assign dout = mem[rp];
  assign valid = count != 2'd0;
endmodule

// File: rtl/shake_squeeze.sv
// shake_squeeze: streams requested output words out of the sha3 state,
// triggering further permutations whenever a full rate block has been read.
module shake_squeeze
  import shake_squeeze_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [CNT_W-1:0]  out_words,
  output logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_dout,
  output logic              core_next,
  input  logic              core_ready,
  output logic [31:0]       dout,
  output logic              valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);
  state_t state, state_n;
  logic mode_q, inflight, issue, pop, drained;
  logic [CNT_W-1:0] rem;
  logic [ADDR_W-1:0] idx, rate;
  logic [1:0] pc, cnt;
  assign rate = rate_of(mode_q);
  assign pop = valid && out_ready;
  assign issue = state == READ && rem != '0 && idx < rate && (2'(inflight) + cnt) < 2'd2;
  // Finish as soon as the last buffered word leaves, so done trails it by one cycle.
  assign drained = !inflight && (cnt == 2'd0 || (cnt == 2'd1 && pop));
  assign core_addr = issue ? idx : '0;
  assign core_next = state == PERMUTE && pc == 2'd0;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (start) state_n = out_words == '0 ? DONE : WAIT_CORE;
      WAIT_CORE: if (core_ready) state_n = READ;
      READ:      state_n = rem == '0 && drained ? DONE :
                           idx == rate && rem != '0 && !inflight && cnt == 2'd0 ? PERMUTE : READ;
      PERMUTE:   if (pc == 2'd2 && core_ready) state_n = READ;
      DONE:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mode_q <= 1'b0;
      rem <= '0;
      idx <= '0;
      inflight <= 1'b0;
      pc <= '0;
    end else begin
      state <= state_n;
      inflight <= issue;
      if (state == IDLE && start) begin
        mode_q <= mode;
        rem <= out_words;
      end else if (issue) begin
        rem <= rem - 1'b1;
      end
      idx <= state != READ && state_n == READ ? '0 : issue ? idx + 1'b1 : idx;
      // pc 0 pulses core_next, 1 skips the stale core_ready, 2 waits for ready
      pc <= state != PERMUTE ? 2'd0 : pc == 2'd2 ? pc : pc + 2'd1;
    end
  end
  shake_out_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .din   (core_dout),
    .pop   (pop),
    .dout  (dout),
    .valid (valid),
    .count (cnt)
  );
endmodule
